// File: rtl/vpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vpu_pkg
// Description : Shared types for the VPU sequencer: VPU mode encoding,
//               sequencer state encoding, latched command fields, and the
//               state-to-mode mapping.
// Revision    : 1.0 - initial release
// ============================================================================
package vpu_pkg;

    // VPU datapath mode; MODE_BYPASS is reserved and never driven
    typedef enum logic [1:0] {
        MODE_IDLE   = 2'b00,
        MODE_ACCUM  = 2'b01,
        MODE_OUTPUT = 2'b10,
        MODE_BYPASS = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ACCUM = 3'd2,
        ST_FINAL = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } vpu_seq_state_e;

    // Final-pass configuration captured when a command is taken
    typedef struct packed {
        logic        bias_en;
        logic        relu_en;
        logic        dequant_en;
        logic [31:0] scale;
    } vpu_cmd_t;

    // Mode the VPU sees while the sequencer sits in a given state
    function automatic mode_e mode_for_state(input vpu_seq_state_e st);
        mode_e m;
        m = MODE_IDLE;
        if (st == ST_ACCUM) begin
            m = MODE_ACCUM;
        end else if ((st == ST_FINAL) || (st == ST_DRAIN)) begin
            m = MODE_OUTPUT;
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vpu_beat_counter.sv
`default_nettype none
// ============================================================================
// Module      : vpu_beat_counter
// Description : Beat counter up to LIMIT. In wrap mode it rolls over to 0
//               after LIMIT-1 and pulses hit_o on the rolling beat. In
//               saturating mode it stops at LIMIT and hit_o reports that
//               LIMIT is reached, including the beat of the current cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module vpu_beat_counter #(
    parameter int LIMIT    = 16,
    parameter bit SATURATE = 1'b0,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic hit_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    generate
        if (SATURATE) begin : g_sat
            localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(LIMIT);

            // Count up and hold at LIMIT
            always_comb begin
                cnt_d = cnt_q;
                if (inc_i && (cnt_q != C_LIMIT)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            assign hit_o = (cnt_d == C_LIMIT);
        end else begin : g_wrap
            localparam logic [CNT_W-1:0] C_LAST = CNT_W'(LIMIT - 1);

            assign hit_o = inc_i && (cnt_q == C_LAST);

            // Count up and roll over after the last beat of a batch
            always_comb begin
                cnt_d = cnt_q;
                if (inc_i) begin
                    cnt_d = hit_o ? '0 : (cnt_q + CNT_W'(1));
                end
            end
        end
    endgenerate

    // Counter register; clear has priority over counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vpu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vpu_seq_ctrl
// Description : Command-driven sequencer for the vector post-processing
//               unit. Walks CLEAR -> ACCUM -> FINAL -> DRAIN -> DONE by
//               counting systolic-array and VPU output beats and drives the
//               VPU shared controls from registers.
// Revision    : 1.0 - initial release
// ============================================================================
module vpu_seq_ctrl
    import vpu_pkg::*;
#(
    parameter int BATCH_SIZE    = 16,
    parameter int K_W           = 8,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [K_W-1:0] cmd_k_tiles,
    input  logic           cmd_bias_en,
    input  logic           cmd_relu_en,
    input  logic           cmd_dequant_en,
    input  logic [31:0]    cmd_scale,
    input  logic           abort,
    input  logic           sa_beat,
    input  logic           out_beat,
    output logic [1:0]     mode_select,
    output logic           psum_clear,
    output logic           psum_enable,
    output logic           bias_enable,
    output logic           relu_enable,
    output logic           dequant_enable,
    output logic [31:0]    scale_fp32,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam int BEAT_W = $clog2(BATCH_SIZE);
    localparam int OUT_W  = $clog2(BATCH_SIZE + 1);
    localparam int TO_W   = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(DRAIN_TIMEOUT - 1);

    vpu_seq_state_e state_q;
    vpu_seq_state_e state_d;
    vpu_cmd_t       cmd_q;
    logic [K_W-1:0] k_tiles_q;
    logic [K_W-1:0] tile_cnt_q;
    logic [TO_W-1:0] to_cnt_q;

    mode_e          mode_q;
    logic           psum_clear_q;
    logic           psum_enable_q;
    logic           bias_q;
    logic           relu_q;
    logic           dequant_q;
    logic [31:0]    scale_q;
    logic           busy_q;
    logic           done_q;
    logic           err_q;

    logic in_accum;
    logic in_final;
    logic in_out_phase;
    logic sa_count_en;
    logic sa_wrap;
    logic out_full;
    logic last_tile;
    logic abort_take;
    logic reject;
    logic timeout_hit;
    logic out_phase_d;

    assign in_accum     = (state_q == ST_ACCUM);
    assign in_final     = (state_q == ST_FINAL);
    assign in_out_phase = in_final || (state_q == ST_DRAIN);
    assign sa_count_en  = in_accum || in_final;
    // The tile that is wrapping now is the last one accumulated before FINAL
    assign last_tile    = (tile_cnt_q == (k_tiles_q - K_W'(2)));
    assign abort_take   = abort && (state_q != ST_IDLE);

    // Beats within the current K-tile; held at zero outside ACCUM/FINAL
    vpu_beat_counter #(
        .LIMIT    (BATCH_SIZE),
        .SATURATE (1'b0),
        .CNT_W    (BEAT_W)
    ) u_sa_cnt (
        .clk   (clk),
        .rst_n (rst),
        .clr_i (!sa_count_en),
        .inc_i (sa_beat && sa_count_en),
        .hit_o (sa_wrap)
    );

    // VPU output beats of the final pass; zero on entry to FINAL
    vpu_beat_counter #(
        .LIMIT    (BATCH_SIZE),
        .SATURATE (1'b1),
        .CNT_W    (OUT_W)
    ) u_out_cnt (
        .clk   (clk),
        .rst_n (rst),
        .clr_i (!in_out_phase),
        .inc_i (out_beat && in_out_phase),
        .hit_o (out_full)
    );

    // Next-state decision; abort overrides every other transition
    always_comb begin
        state_d     = state_q;
        reject      = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_k_tiles == '0) begin
                        reject = 1'b1;
                    end else begin
                        state_d = ST_CLEAR;
                    end
                end
            end
            ST_CLEAR: begin
                state_d = (k_tiles_q > K_W'(1)) ? ST_ACCUM : ST_FINAL;
            end
            ST_ACCUM: begin
                if (sa_wrap && last_tile) begin
                    state_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                if (sa_wrap) begin
                    state_d = out_full ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_full) begin
                    state_d = ST_DONE;
                end else if (to_cnt_q == C_TO_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort_take) begin
            state_d     = ST_IDLE;
            timeout_hit = 1'b0;
        end
    end

    assign out_phase_d = (state_d == ST_FINAL) || (state_d == ST_DRAIN);

    // State register, command capture and registered VPU controls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cmd_q         <= '0;
            k_tiles_q     <= '0;
            mode_q        <= MODE_IDLE;
            psum_clear_q  <= 1'b0;
            psum_enable_q <= 1'b0;
            bias_q        <= 1'b0;
            relu_q        <= 1'b0;
            dequant_q     <= 1'b0;
            scale_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && cmd_valid) begin
                k_tiles_q <= cmd_k_tiles;
                cmd_q     <= '{bias_en:    cmd_bias_en,
                               relu_en:    cmd_relu_en,
                               dequant_en: cmd_dequant_en,
                               scale:      cmd_scale};
            end
            mode_q        <= mode_for_state(state_d);
            psum_clear_q  <= (state_d == ST_CLEAR) || abort_take;
            psum_enable_q <= (state_d == ST_ACCUM) || out_phase_d;
            bias_q        <= out_phase_d && cmd_q.bias_en;
            relu_q        <= out_phase_d && cmd_q.relu_en;
            dequant_q     <= out_phase_d && cmd_q.dequant_en;
            scale_q       <= out_phase_d ? cmd_q.scale : 32'h0;
            busy_q        <= (state_d != ST_IDLE);
            done_q        <= (state_d == ST_DONE) && !abort_take;
            err_q         <= reject || timeout_hit;
        end
    end

    // K-tile counter; restarts in CLEAR and advances on each ACCUM tile wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tile_cnt_q <= '0;
        end else if (state_q == ST_CLEAR) begin
            tile_cnt_q <= '0;
        end else if (in_accum && sa_wrap) begin
            tile_cnt_q <= tile_cnt_q + K_W'(1);
        end
    end

    // Drain timeout counter; runs only while in DRAIN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q <= '0;
        end else if (state_q != ST_DRAIN) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    assign cmd_ready      = (state_q == ST_IDLE);
    assign mode_select    = mode_q;
    assign psum_clear     = psum_clear_q;
    assign psum_enable    = psum_enable_q;
    assign bias_enable    = bias_q;
    assign relu_enable    = relu_q;
    assign dequant_enable = dequant_q;
    assign scale_fp32     = scale_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule
`default_nettype wire

// File: doc/vpu_seq_ctrl.md
Name: vpu_seq_ctrl

Overview:
- Command-driven sequencer for the vector post-processing unit.
- Accepts one tile-job command per transaction: K-tile count, bias/ReLU/dequant enables and FP32 scale.
- Drives the VPU's shared control inputs (mode_select, psum_clear, psum_enable, bias/relu/dequant enables, scale) through clear, accumulate, final and drain phases by counting systolic-array output beats and VPU output beats.
- Sits between the top-level instruction decoder and all VPU channels; one instance per VPU.

Parameters:
- BATCH_SIZE, 16, beats (rows) per K-tile; power of two, at least 2.
- K_W, 8, width of the K-tile count field.
- DRAIN_TIMEOUT, 64, maximum cycles in DRAIN before the error flag is raised.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_k_tiles  in  K_W  number of K-tiles to accumulate; 0 is illegal
- cmd_bias_en  in  1  apply bias in final pass
- cmd_relu_en  in  1  apply ReLU in final pass
- cmd_dequant_en  in  1  apply dequant in final pass
- cmd_scale  in  32  FP32 dequant scale
- abort  in  1  synchronous abort of the current job
- sa_beat  in  1  one systolic-array output beat presented to the VPU this cycle
- out_beat  in  1  one VPU output beat produced this cycle
- mode_select  out  2  VPU mode
- psum_clear  out  1  one-cycle partial-sum clear
- psum_enable  out  1  accumulate into psum buffer
- bias_enable, relu_enable, dequant_enable  out  1 each  final-pass enables
- scale_fp32  out  32  scale presented to the VPU
- busy  out  1  job in progress
- done  out  1  one-cycle job completion pulse
- err  out  1  one-cycle pulse: illegal command or drain timeout

Behaviour:
- State machine: IDLE, CLEAR, ACCUM, FINAL, DRAIN, DONE.
- Output registration:
  - All outputs are registered except cmd_ready, which is (state==IDLE).
  - busy is 1 in any state other than IDLE.
- Reset values:
  - state IDLE; mode_select MODE_IDLE; all enables, psum_clear, done, err and scale_fp32 are 0.
  - All counters are 0.
  - cmd_ready reads 1 during reset.

State transitions:
- IDLE:
  - On cmd_valid, latch all cmd_* fields.
  - If cmd_k_tiles==0: pulse err next cycle, remain in IDLE, drop the command.
  - Otherwise go to CLEAR.
- CLEAR:
  - psum_clear=1 for exactly one cycle; tile_cnt and beat_cnt are zeroed.
  - Next state is ACCUM if k_tiles>1, else FINAL.
- ACCUM:
  - mode_select=MODE_ACCUM, psum_enable=1.
  - Each sa_beat increments beat_cnt. At beat_cnt==BATCH_SIZE-1 with sa_beat, beat_cnt wraps to 0 and tile_cnt increments.
  - When the wrapping tile reaches tile_cnt==k_tiles-2, go to FINAL.
- FINAL:
  - mode_select=MODE_OUTPUT, psum_enable=1; bias/relu/dequant enables follow the latched flags; scale_fp32 is the latched scale.
  - out_cnt is cleared on entry and counts out_beat in FINAL and DRAIN.
  - After BATCH_SIZE sa_beats: go to DONE if out_cnt has already reached BATCH_SIZE (counting the current beat), else go to DRAIN.
- DRAIN:
  - Outputs held as in FINAL; timeout counter increments each cycle.
  - out_cnt reaching BATCH_SIZE goes to DONE.
  - Timeout reaching DRAIN_TIMEOUT pulses err and goes to DONE.
- DONE:
  - done=1 for one cycle; enables drop to 0 and mode returns to MODE_IDLE; next state is IDLE.

Latency:
- Command accepted at cycle t gives psum_clear at t+1.
- mode_select=ACCUM (or OUTPUT when k_tiles==1) at t+2.

Boundary and exception rules:
- sa_beat in IDLE, CLEAR or DONE is ignored.
- out_beat outside FINAL/DRAIN is ignored.
- out_cnt saturates at BATCH_SIZE; it has width $clog2(BATCH_SIZE+1).
- abort in any non-IDLE state: next cycle psum_clear=1, all enables 0, mode IDLE, state IDLE, no done pulse. abort in IDLE has no effect.
- abort has priority over every other transition, including same-cycle beat wrap and timeout.
- Reset asserted mid-job returns asynchronously to reset values; the latched command is lost.
- k_tiles=2^K_W-1 must complete; the tile counter does not overflow.

Decomposition:
- Package vpu_pkg:
  - mode_e enum: MODE_IDLE=2'b00, MODE_ACCUM=2'b01, MODE_OUTPUT=2'b10, MODE_BYPASS=2'b11 (reserved, never driven).
  - vpu_seq_state_e enum.
  - vpu_cmd_t struct holding the latched command fields.
- One sub-module, vpu_beat_counter: wrap-at-BATCH_SIZE beat counter with a wrap pulse, reused for sa_beat counting and for out_cnt in saturating mode.

Test Plan:
- k_tiles=3, all enables 0, sa_beat every cycle, out_beat lags by 2:
  - psum_clear one cycle at t+1; ACCUM for 32 beats; FINAL for 16 beats; done after the 16th out_beat; mode_select sequence 0,1,2,0.
- k_tiles=1, bias=1, relu=1, dequant=1, scale=0x3F800000:
  - CLEAR goes straight to FINAL; all three enables high only in FINAL/DRAIN; scale_fp32=0x3F800000; done after 16 out_beats.
- k_tiles=0:
  - err pulse one cycle; cmd_ready stays 1; psum_clear never asserts.
- k_tiles=2, out_beat never asserted:
  - DRAIN lasts 64 cycles; err and done pulse on the same cycle; return to IDLE.
- abort during ACCUM at beat 7 of tile 0, with sa_beat in the same cycle:
  - next cycle psum_clear=1, mode=0, busy=0, no done.
  - A new command is accepted the following cycle.
- rst asserted during FINAL:
  - all outputs go to reset values asynchronously; after release cmd_ready=1 and a fresh k_tiles=1 job completes normally.
